instr_register_alu: RTL and testbench

- Parametrised next-generation instruction register.
- Stores {opcode, operand_a, operand_b, result} per entry; the result is computed by an internal 2-stage pipelined ALU before the entry is committed.
- Adds:
  - configurable depth and operand width
  - per-entry valid tracking
  - registered read port with write-to-read bypass
  - divide-by-zero accounting
- Sits between the instruction generator/testbench and the scoreboard; it is the DUT for the self-checking bench.

---
 rtl/instr_register_pkg.sv | 29 ++
 rtl/instr_register_alu_if.sv | 45 ++++
 rtl/instr_alu.sv | 45 ++++
 rtl/instr_register_alu.sv | 137 +++++++++++++
 tb/tb_instr_register_alu.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register slice.
// Opcode encoding plus default-width operand, result and entry types.
package instr_register_pkg;

   typedef enum logic [2:0] {
      ZERO,
      PASSA,
      PASSB,
      ADD,
      SUB,
      MULT,
      DIV,
      MOD
   } opcode_t;

   localparam int OP_W_DEF  = 32;
   localparam int RES_W_DEF = 2 * OP_W_DEF;

   typedef logic signed [OP_W_DEF-1:0]  operand_t;
   typedef logic signed [RES_W_DEF-1:0] result_t;

   typedef struct packed {
      opcode_t  opc;
      operand_t op_a;
      operand_t op_b;
      result_t  result;
   } instruction_t;

endpackage

// File: rtl/instr_register_alu_if.sv
// Write/read bus of the instruction register.
// The master drives writes and read pointers; the slave returns data.
interface instr_register_alu_if #(
   parameter int DEPTH = 32,
   parameter int OP_W  = 32
);
   import instr_register_pkg::*;

   localparam int AW    = $clog2(DEPTH);
   localparam int RES_W = 2 * OP_W;

   typedef struct packed {
      opcode_t                 opc;
      logic signed [OP_W-1:0]  op_a;
      logic signed [OP_W-1:0]  op_b;
      logic signed [RES_W-1:0] result;
   } word_t;

   logic                   load_en;
   logic [AW-1:0]          write_pointer;
   opcode_t                opcode;
   logic signed [OP_W-1:0] operand_a;
   logic signed [OP_W-1:0] operand_b;
   logic [AW-1:0]          read_pointer;
   word_t                  instruction_word;
   logic                   read_valid;
   logic                   busy;
   logic [AW:0]            valid_count;
   logic [15:0]            div0_count;

   modport master (
      output load_en, write_pointer, opcode,
      output operand_a, operand_b, read_pointer,
      input  instruction_word, read_valid, busy,
      input  valid_count, div0_count
   );

   modport slave (
      input  load_en, write_pointer, opcode,
      input  operand_a, operand_b, read_pointer,
      output instruction_word, read_valid, busy,
      output valid_count, div0_count
   );

endinterface

// File: rtl/instr_alu.sv
// Combinational signed ALU used in the second write stage.
// Operands are sign-extended to the double-width result.
module instr_alu
   import instr_register_pkg::*;
#(
   parameter int OP_W = 32
) (
   input  opcode_t                  opc_i,
   input  logic signed [OP_W-1:0]   a_i,
   input  logic signed [OP_W-1:0]   b_i,
   output logic signed [2*OP_W-1:0] res_o,
   output logic                     div0_o
);

   localparam int RES_W = 2 * OP_W;

   logic signed [RES_W-1:0] ax;
   logic signed [RES_W-1:0] bx;

   // Decode the opcode; a zero divisor yields 0 and raises div0
   always_comb begin
      ax     = {{OP_W{a_i[OP_W-1]}}, a_i};
      bx     = {{OP_W{b_i[OP_W-1]}}, b_i};
      res_o  = '0;
      div0_o = 1'b0;
      unique case (opc_i)
         ZERO:  res_o = '0;
         PASSA: res_o = ax;
         PASSB: res_o = bx;
         ADD:   res_o = ax + bx;
         SUB:   res_o = ax - bx;
         MULT:  res_o = ax * bx;
         DIV: begin
            if (b_i == '0) div0_o = 1'b1;
            else           res_o  = ax / bx;
         end
         MOD: begin
            if (b_i == '0) div0_o = 1'b1;
            else           res_o  = ax % bx;
         end
         default: res_o = '0;
      endcase
   end

endmodule

// File: rtl/instr_register_alu.sv
// Instruction register with a 2-stage ALU write pipeline.
// Registered read port bypasses a same-edge commit.
module instr_register_alu
   import instr_register_pkg::*;
#(
   parameter int DEPTH = 32,
   parameter int OP_W  = 32
) (
   input logic                clk,
   input logic                reset,
   instr_register_alu_if.slave bus
);

   localparam int AW    = $clog2(DEPTH);
   localparam int RES_W = 2 * OP_W;

   typedef struct packed {
      opcode_t                 opc;
      logic signed [OP_W-1:0]  op_a;
      logic signed [OP_W-1:0]  op_b;
      logic signed [RES_W-1:0] result;
   } entry_t;

   logic                    s1_vld_q;
   logic [AW-1:0]           s1_ptr_q;
   opcode_t                 s1_opc_q;
   logic signed [OP_W-1:0]  s1_a_q;
   logic signed [OP_W-1:0]  s1_b_q;

   logic                    s2_vld_q;
   logic [AW-1:0]           s2_ptr_q;
   entry_t                  s2_ent_q;
   logic                    s2_div0_q;

   logic signed [RES_W-1:0] alu_res;
   logic                    alu_div0;

   entry_t                  mem_q [DEPTH];
   logic [DEPTH-1:0]        valid_q;
   logic [AW:0]             vcnt_q, vcnt_d;
   logic [15:0]             d0_q, d0_d;
   entry_t                  rd_q;
   logic                    rv_q;
   logic                    byp;

   instr_alu #(.OP_W(OP_W)) u_alu (
      .opc_i  (s1_opc_q),
      .a_i    (s1_a_q),
      .b_i    (s1_b_q),
      .res_o  (alu_res),
      .div0_o (alu_div0)
   );

   // Stage 1: capture the write request
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_vld_q <= 1'b0;
         s1_ptr_q <= '0;
         s1_opc_q <= ZERO;
         s1_a_q   <= '0;
         s1_b_q   <= '0;
      end else begin
         s1_vld_q <= bus.load_en;
         if (bus.load_en) begin
            s1_ptr_q <= bus.write_pointer;
            s1_opc_q <= bus.opcode;
            s1_a_q   <= bus.operand_a;
            s1_b_q   <= bus.operand_b;
         end
      end
   end

   // Stage 2: register the ALU result with the entry fields
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s2_vld_q  <= 1'b0;
         s2_ptr_q  <= '0;
         s2_ent_q  <= '0;
         s2_div0_q <= 1'b0;
      end else begin
         s2_vld_q  <= s1_vld_q;
         s2_ptr_q  <= s1_ptr_q;
         s2_ent_q  <= '{s1_opc_q, s1_a_q, s1_b_q, alu_res};
         s2_div0_q <= s1_vld_q & alu_div0;
      end
   end

   // Counter next state: new-entry count and saturating div0 count
   always_comb begin
      vcnt_d = vcnt_q;
      d0_d   = d0_q;
      if (s2_vld_q) begin
         if (!valid_q[s2_ptr_q]) vcnt_d = vcnt_q + (AW+1)'(1);
         if (s2_div0_q && d0_q != 16'hFFFF) d0_d = d0_q + 16'd1;
      end
   end

   // Commit: write storage, mark valid, update counters
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         valid_q <= '0;
         vcnt_q  <= '0;
         d0_q    <= '0;
      end else begin
         if (s2_vld_q) begin
            mem_q[s2_ptr_q]   <= s2_ent_q;
            valid_q[s2_ptr_q] <= 1'b1;
         end
         vcnt_q <= vcnt_d;
         d0_q   <= d0_d;
      end
   end

   assign byp = s2_vld_q && (s2_ptr_q == bus.read_pointer);

   // Registered read with same-edge commit bypass
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_q <= '0;
         rv_q <= 1'b0;
      end else if (byp) begin
         rd_q <= s2_ent_q;
         rv_q <= 1'b1;
      end else begin
         rd_q <= mem_q[bus.read_pointer];
         rv_q <= valid_q[bus.read_pointer];
      end
   end

   assign bus.instruction_word = rd_q;
   assign bus.read_valid       = rv_q;
   assign bus.busy             = s1_vld_q | s2_vld_q;
   assign bus.valid_count      = vcnt_q;
   assign bus.div0_count       = d0_q;

endmodule

// File: tb/tb_instr_register_alu.sv
// Scoreboard bench for instr_register_alu.
// Driver queues expected read results; monitor pops after each edge.
module tb_instr_register_alu;
   import instr_register_pkg::*;

   localparam int DEPTH = 32;
   localparam int OP_W  = 32;
   localparam int AW    = $clog2(DEPTH);

   typedef struct {
      string   nm;
      bit      cw;
      opcode_t opc;
      longint  a;
      longint  b;
      longint  res;
      bit      rv;
      bit      busy;
      bit      cc;
      int      vc;
      int      d0;
   } exp_t;

   logic clk;
   logic reset;
   bit   chk;
   int   errors;
   int   checks;
   exp_t q[$];

   instr_register_alu_if #(.DEPTH(DEPTH), .OP_W(OP_W)) bus ();

   instr_register_alu #(.DEPTH(DEPTH), .OP_W(OP_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void check(bit ok, string nm, string got, string want);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %s, want %s", nm, got, want);
      end
   endfunction

   function automatic exp_t mk(string nm, opcode_t opc, longint a, longint b,
                               longint res, bit rv, bit busy, int vc, int d0);
      exp_t e;
      e.nm = nm; e.cw = 1'b1; e.opc = opc; e.a = a; e.b = b; e.res = res;
      e.rv = rv; e.busy = busy; e.cc = 1'b1; e.vc = vc; e.d0 = d0;
      return e;
   endfunction

   function automatic exp_t bz(string nm, bit busy);
      exp_t e;
      e = mk(nm, ZERO, 0, 0, 0, 1'b0, busy, 0, 0);
      e.cw = 1'b0;
      e.cc = 1'b0;
      return e;
   endfunction

   function automatic longint alu_ref(opcode_t op, longint a, longint b);
      case (op)
         ZERO:    return 0;
         PASSA:   return a;
         PASSB:   return b;
         ADD:     return a + b;
         SUB:     return a - b;
         MULT:    return a * b;
         DIV:     return (b == 0) ? 0 : a / b;
         MOD:     return (b == 0) ? 0 : a % b;
         default: return 0;
      endcase
   endfunction

   task automatic cyc(bit ld, int wp, opcode_t op, longint a, longint b,
                      int rp, exp_t e);
      @(negedge clk);
      bus.load_en       = ld;
      bus.write_pointer = AW'(wp);
      bus.opcode        = op;
      bus.operand_a     = a[OP_W-1:0];
      bus.operand_b     = b[OP_W-1:0];
      bus.read_pointer  = AW'(rp);
      chk               = 1'b1;
      q.push_back(e);
   endtask

   task automatic do_reset(string nm);
      @(negedge clk);
      chk         = 1'b0;
      bus.load_en = 1'b0;
      reset       = 1'b1;
      #1;
      check(bus.instruction_word == '0, {nm, "_word"},
            $sformatf("%h", bus.instruction_word), "0");
      check(bus.read_valid == 1'b0, {nm, "_rv"},
            $sformatf("%0b", bus.read_valid), "0");
      check(bus.busy == 1'b0, {nm, "_busy"},
            $sformatf("%0b", bus.busy), "0");
      check(bus.valid_count == '0, {nm, "_vc"},
            $sformatf("%0d", bus.valid_count), "0");
      check(bus.div0_count == '0, {nm, "_d0"},
            $sformatf("%0d", bus.div0_count), "0");
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   // Monitor: compare the read port and status one step after each edge
   always @(posedge clk) begin
      if (chk) begin
         exp_t e;
         #1;
         if (q.size() == 0) begin
            check(1'b0, "queue", "empty", "item");
         end else begin
            e = q.pop_front();
            if (e.cw) begin
               check(bus.instruction_word.opc == e.opc &&
                     $signed(bus.instruction_word.op_a) == e.a &&
                     $signed(bus.instruction_word.op_b) == e.b &&
                     $signed(bus.instruction_word.result) == e.res,
                     {e.nm, "_word"},
                     $sformatf("opc=%0d a=%0d b=%0d res=%0d",
                        bus.instruction_word.opc,
                        $signed(bus.instruction_word.op_a),
                        $signed(bus.instruction_word.op_b),
                        $signed(bus.instruction_word.result)),
                     $sformatf("opc=%0d a=%0d b=%0d res=%0d",
                        e.opc, e.a, e.b, e.res));
               check(bus.read_valid == e.rv, {e.nm, "_rv"},
                     $sformatf("%0b", bus.read_valid),
                     $sformatf("%0b", e.rv));
            end
            check(bus.busy == e.busy, {e.nm, "_busy"},
                  $sformatf("%0b", bus.busy), $sformatf("%0b", e.busy));
            if (e.cc) begin
               check(int'(bus.valid_count) == e.vc, {e.nm, "_vc"},
                     $sformatf("%0d", bus.valid_count),
                     $sformatf("%0d", e.vc));
               check(int'(bus.div0_count) == e.d0, {e.nm, "_d0"},
                     $sformatf("%0d", bus.div0_count),
                     $sformatf("%0d", e.d0));
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      opcode_t op;
      longint  a;
      longint  b;

      errors = 0;
      checks = 0;
      chk    = 1'b0;
      reset  = 1'b0;
      bus.load_en       = 1'b0;
      bus.write_pointer = '0;
      bus.opcode        = ZERO;
      bus.operand_a     = '0;
      bus.operand_b     = '0;
      bus.read_pointer  = '0;

      do_reset("por");
      cyc(0, 0, ZERO, 0, 0, 0, mk("rst_rd", ZERO, 0, 0, 0, 0, 0, 0, 0));

      // ADD into ptr 5, observed through the pipeline and bypass
      cyc(1, 5, ADD, 7, -3, 5, mk("add_n", ZERO, 0, 0, 0, 0, 1, 0, 0));
      cyc(0, 0, ZERO, 0, 0, 5, mk("add_n1", ZERO, 0, 0, 0, 0, 1, 0, 0));
      cyc(0, 0, ZERO, 0, 0, 5, mk("add_byp", ADD, 7, -3, 4, 1, 0, 1, 0));
      cyc(0, 0, ZERO, 0, 0, 5, mk("add_rd", ADD, 7, -3, 4, 1, 0, 1, 0));

      // Back-to-back writes to ptr 3
      do_reset("rst_bb");
      cyc(1, 3, MULT, -6, 5, 3, mk("bb_a", ZERO, 0, 0, 0, 0, 1, 0, 0));
      cyc(1, 3, SUB, 2, 9, 3, mk("bb_b", ZERO, 0, 0, 0, 0, 1, 0, 0));
      cyc(0, 0, ZERO, 0, 0, 3, mk("bb_c", MULT, -6, 5, -30, 1, 1, 1, 0));
      cyc(0, 0, ZERO, 0, 0, 3, mk("bb_d", SUB, 2, 9, -7, 1, 0, 1, 0));
      cyc(0, 0, ZERO, 0, 0, 3, mk("bb_e", SUB, 2, 9, -7, 1, 0, 1, 0));

      // Signed division, modulo and divide by zero
      do_reset("rst_dv");
      cyc(1, 0, DIV, -7, 2, 0, bz("dv_l0", 1));
      cyc(1, 1, MOD, -7, 2, 1, bz("dv_l1", 1));
      cyc(1, 2, DIV, 9, 0, 0, mk("dv_l2", DIV, -7, 2, -3, 1, 1, 1, 0));
      cyc(0, 0, ZERO, 0, 0, 1, mk("dv_i0", MOD, -7, 2, -1, 1, 1, 2, 0));
      cyc(0, 0, ZERO, 0, 0, 2, mk("dv_i1", DIV, 9, 0, 0, 1, 0, 3, 1));
      cyc(0, 0, ZERO, 0, 0, 0, mk("dv_r0", DIV, -7, 2, -3, 1, 0, 3, 1));

      // Fill every entry, then read all back
      do_reset("rst_fill");
      for (int i = 0; i < DEPTH; i++) begin
         op = opcode_t'(i % 8);
         a  = i * 37 - 500;
         b  = (i % 2 == 0) ? i + 1 : -(i + 2);
         cyc(1, i, op, a, b, i, bz("fill", 1));
      end
      cyc(0, 0, ZERO, 0, 0, 0, bz("fill_i0", 1));
      cyc(0, 0, ZERO, 0, 0, 0, mk("fill_i1", ZERO, -500, 1, 0, 1, 0, 32, 0));
      for (int i = 0; i < DEPTH; i++) begin
         op = opcode_t'(i % 8);
         a  = i * 37 - 500;
         b  = (i % 2 == 0) ? i + 1 : -(i + 2);
         cyc(0, 0, ZERO, 0, 0, i,
             mk($sformatf("fill_rd%0d", i), op, a, b, alu_ref(op, a, b),
                1, 0, 32, 0));
      end
      cyc(1, 0, ADD, 1, 1, 0, bz("rw_l", 1));
      cyc(0, 0, ZERO, 0, 0, 0, bz("rw_s2", 1));
      cyc(0, 0, ZERO, 0, 0, 0, mk("rewr", ADD, 1, 1, 2, 1, 0, 32, 0));

      // Reset with two writes in flight
      cyc(1, 7, ADD, 1, 2, 7, bz("if0", 1));
      cyc(1, 8, SUB, 1, 2, 8, bz("if1", 1));
      do_reset("rst_if");
      cyc(0, 0, ZERO, 0, 0, 7, mk("if_r7", ZERO, 0, 0, 0, 0, 0, 0, 0));
      cyc(0, 0, ZERO, 0, 0, 8, mk("if_r8", ZERO, 0, 0, 0, 0, 0, 0, 0));
      cyc(0, 0, ZERO, 0, 0, 7, mk("if_r7b", ZERO, 0, 0, 0, 0, 0, 0, 0));
      cyc(0, 0, ZERO, 0, 0, 0, mk("if_r0", ZERO, 0, 0, 0, 0, 0, 0, 0));

      @(negedge clk);
      chk = 1'b0;
      repeat (2) @(negedge clk);
      check(q.size() == 0, "drain", $sformatf("%0d", q.size()), "0");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
